sudoku_solve_ctrl: RTL and testbench

- Iterative sequencer wrapped around the combinational soduku_solver datapath.
- Captures an unsolved board and drives it into the solver.
- Feeds each solver result back as the next input until one of three things happens: the board is fully solved, a pass makes no progress, or an iteration cap is reached.
- Sits between the board-capture front end and the display/output logic, and exposes a start/busy/done handshake.

---
 rtl/sudoku_solve_ctrl_if.sv | 38 +++
 rtl/sudoku_solve_ctrl.sv | 108 ++++++++++
 tb/tb_sudoku_solve_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sudoku_solve_ctrl_if.sv
// Handshake and board buses between sudoku_solve_ctrl, its front end and the solver datapath.
// abort_in exists only when SUDOKU_CTRL_ABORT_EN is defined.
interface sudoku_solve_ctrl_if #(
  parameter int GRID_SIZE = 9,
  parameter int MAX_ITER  = 81
);
  localparam int BW = 4 * GRID_SIZE * GRID_SIZE;
  localparam int IW = $clog2(MAX_ITER + 1);

  logic          start_in;
  logic [BW-1:0] board_in;
  logic [BW-1:0] solver_board_out;
  logic [BW-1:0] solver_board_in;
  logic [BW-1:0] board_out;
  logic          busy_out;
  logic          done_out;
  logic [1:0]    status_out;
  logic [IW-1:0] iter_out;
`ifdef SUDOKU_CTRL_ABORT_EN
  logic          abort_in;
`endif

  modport slave (
`ifdef SUDOKU_CTRL_ABORT_EN
    input  abort_in,
`endif
    input  start_in, board_in, solver_board_in,
    output solver_board_out, board_out, busy_out, done_out, status_out, iter_out
  );

  modport master (
`ifdef SUDOKU_CTRL_ABORT_EN
    output abort_in,
`endif
    output start_in, board_in, solver_board_in,
    input  solver_board_out, board_out, busy_out, done_out, status_out, iter_out
  );
endinterface

// File: rtl/sudoku_solve_ctrl.sv
// Iterative sequencer around the combinational sudoku solver: feeds each result back until solved,
// stuck or the pass cap is hit. Optional abort input enabled by SUDOKU_CTRL_ABORT_EN.
module sudoku_solve_ctrl #(
  parameter int GRID_SIZE     = 9,
  parameter int MAX_ITER      = 81,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                clk_in,
  input  logic                reset_in,
  sudoku_solve_ctrl_if.slave  bus
);
  localparam int NCELL = GRID_SIZE * GRID_SIZE;
  localparam int BW    = 4 * NCELL;
  localparam int IW    = $clog2(MAX_ITER + 1);
  localparam int SW    = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_EVAL, ST_DONE} state_t;

  state_t        r_state, w_next;
  logic [BW-1:0] r_work, r_board;
  logic [1:0]    r_status;
  logic [IW-1:0] r_iter;
  logic [SW-1:0] r_settle;

  logic          w_full, w_same, w_last, w_stop, w_abort;
  logic [1:0]    w_code;
  logic [IW-1:0] w_iter_inc;

  always_comb begin
    w_full = 1'b1;
    for (int unsigned i = 0; i < NCELL; i++) begin
      if (bus.solver_board_in[4*i +: 4] == 4'd0) w_full = 1'b0;
    end
  end

  assign w_same     = (bus.solver_board_in == r_work);
  assign w_iter_inc = r_iter + IW'(1);
  assign w_last     = (w_iter_inc == IW'(MAX_ITER));
  assign w_stop     = w_full | w_same | w_last;
  assign w_code     = w_full ? 2'b01 : (w_same ? 2'b10 : 2'b11);

`ifdef SUDOKU_CTRL_ABORT_EN
  assign w_abort = bus.abort_in & ((r_state == ST_WAIT) | (r_state == ST_EVAL));
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) r_state <= ST_IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.start_in) w_next = ST_WAIT;
      ST_WAIT: begin
        if (w_abort)             w_next = ST_DONE;
        else if (r_settle == SW'(1)) w_next = ST_EVAL;
      end
      ST_EVAL: w_next = (w_abort | w_stop) ? ST_DONE : ST_WAIT;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Abort keeps the last fed board and the pass count; it outranks every EVAL outcome.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_work   <= '0;
      r_board  <= '0;
      r_status <= 2'b00;
      r_iter   <= '0;
      r_settle <= '0;
    end else if (w_abort) begin
      r_board  <= r_work;
      r_status <= 2'b11;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.start_in) begin
          r_work   <= bus.board_in;
          r_iter   <= '0;
          r_status <= 2'b00;
          r_settle <= SW'(SETTLE_CYCLES);
        end
        ST_WAIT: r_settle <= r_settle - SW'(1);
        ST_EVAL: begin
          r_iter <= w_iter_inc;
          if (w_stop) begin
            r_board  <= bus.solver_board_in;
            r_status <= w_code;
          end else begin
            r_work   <= bus.solver_board_in;
            r_settle <= SW'(SETTLE_CYCLES);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.solver_board_out = r_work;
  assign bus.board_out        = r_board;
  assign bus.status_out       = r_status;
  assign bus.iter_out         = r_iter;
  assign bus.busy_out         = (r_state != ST_IDLE);
  assign bus.done_out         = (r_state == ST_DONE);
endmodule

// File: tb/tb_sudoku_solve_ctrl.sv
// Bench for sudoku_solve_ctrl with a behavioural solver stand-in that fills a fixed number of
// empty cells per pass; expected results come from a pass-by-pass reference of the solve rules.
module tb_sudoku_solve_ctrl;
  localparam int GS = 9;
  localparam int MI = 5;
  localparam int SC = 1;
  localparam int NC = GS * GS;
  localparam int BW = 4 * NC;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   fill_n = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  sudoku_solve_ctrl_if #(.GRID_SIZE(GS), .MAX_ITER(MI)) bus ();

  sudoku_solve_ctrl #(.GRID_SIZE(GS), .MAX_ITER(MI), .SETTLE_CYCLES(SC)) dut (
    .clk_in  (clk),
    .reset_in(rst_n),
    .bus     (bus.slave)
  );

  // Value of cell i in a known valid grid (row 0 reads 1..9).
  function automatic logic [3:0] answer(input int i);
    int r, c;
    r = i / GS;
    c = i % GS;
    return 4'((r * 3 + r / 3 + c) % 9 + 1);
  endfunction

  function automatic logic [BW-1:0] env_solve(input logic [BW-1:0] b, input int fill);
    logic [BW-1:0] o;
    int left;
    o = b;
    left = fill;
    for (int i = 0; i < NC; i++) begin
      if (o[4*(NC-1-i) +: 4] == 4'd0 && left > 0) begin
        o[4*(NC-1-i) +: 4] = answer(i);
        left--;
      end
    end
    return o;
  endfunction

  always_comb bus.solver_board_in = env_solve(bus.solver_board_out, fill_n);

  function automatic logic [BW-1:0] valid_board();
    logic [BW-1:0] o;
    for (int i = 0; i < NC; i++) o[4*(NC-1-i) +: 4] = answer(i);
    return o;
  endfunction

  function automatic logic [BW-1:0] rand_full();
    logic [BW-1:0] o;
    for (int i = 0; i < NC; i++) o[4*i +: 4] = 4'($urandom_range(15, 1));
    return o;
  endfunction

  function automatic logic [BW-1:0] clear_cell(input logic [BW-1:0] b, input int i);
    logic [BW-1:0] o;
    o = b;
    o[4*(NC-1-i) +: 4] = 4'd0;
    return o;
  endfunction

  function automatic int count_zeros(input logic [BW-1:0] b);
    int z = 0;
    for (int i = 0; i < NC; i++) if (b[4*i +: 4] == 4'd0) z++;
    return z;
  endfunction

  // Reference: apply passes until solved, no progress, or the pass cap.
  task automatic ref_solve(input logic [BW-1:0] board, input int fill,
                           output logic [1:0] st, output int it,
                           output logic [BW-1:0] fb, output int lat);
    logic [BW-1:0] work, nxt;
    int k;
    work = board;
    k = 0;
    st = 2'b00;
    fb = '0;
    while (k < MI) begin
      nxt = env_solve(work, fill);
      k++;
      if (count_zeros(nxt) == 0)  st = 2'b01;
      else if (nxt == work)       st = 2'b10;
      else if (k == MI)           st = 2'b11;
      if (st != 2'b00) begin
        fb = nxt;
        break;
      end
      work = nxt;
    end
    it  = k;
    lat = k * (SC + 1) + 1;
  endtask

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_solve(input logic [BW-1:0] board, input int fill, input bit poke);
    logic [1:0] st;
    logic [BW-1:0] fb;
    int it, lat, n, busy_cnt, extra;
    bit seen;
    ref_solve(board, fill, st, it, fb, lat);
    fill_n = fill;
    @(negedge clk);
    bus.board_in = board;
    bus.start_in = 1'b1;
    n = 0;
    busy_cnt = 0;
    seen = 1'b0;
    while (n < 200 && !seen) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 1) begin
        bus.start_in = 1'b0;
        bus.board_in = rand_full();
      end
      if (poke && n == 2) bus.start_in = 1'b1;
      if (poke && n == 3) bus.start_in = 1'b0;
      if (bus.busy_out) busy_cnt++;
      if (bus.done_out) seen = 1'b1;
    end
    check("latency", n, lat);
    check("status", bus.status_out, st);
    check("iter", bus.iter_out, it);
    check("board", bus.board_out, fb);
    check("busy_cycles", busy_cnt, lat);
    extra = 0;
    for (int j = 0; j < lat + 2; j++) begin
      @(posedge clk);
      #1;
      if (bus.done_out) extra++;
    end
    check("no_extra_done", extra, 0);
    check("idle_busy", bus.busy_out, 1'b0);
    check("hold_status", bus.status_out, st);
    check("hold_board", bus.board_out, fb);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BW-1:0] b;
    int n, d1, d2;
    bus.start_in = 1'b0;
    bus.board_in = '0;
`ifdef SUDOKU_CTRL_ABORT_EN
    bus.abort_in = 1'b0;
`endif
    #12;
    check("rst_busy", bus.busy_out, 1'b0);
    check("rst_done", bus.done_out, 1'b0);
    check("rst_status", bus.status_out, 2'b00);
    check("rst_iter", bus.iter_out, 0);
    check("rst_board", bus.board_out, '0);
    check("rst_work", bus.solver_board_out, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full valid board: one pass, done three cycles after start
    run_solve(valid_board(), 1, 1'b0);
    // Single hole at [0][0]
    run_solve(clear_cell(valid_board(), 0), 1, 1'b0);
    check("cell00", bus.board_out[BW-1 -: 4], 4'd1);
    // Three holes, two filled per pass
    b = clear_cell(clear_cell(clear_cell(valid_board(), 0), 5*9+5), 8*9+5);
    run_solve(b, 2, 1'b0);
    // All-zero board with no progress
    run_solve('0, 0, 1'b0);
    // Exactly MI holes one per pass: solved on the last allowed pass
    b = valid_board();
    for (int i = 0; i < MI; i++) b = clear_cell(b, i * 7);
    run_solve(b, 1, 1'b0);
    // MI+2 holes one per pass: timeout
    b = valid_board();
    for (int i = 0; i < MI + 2; i++) b = clear_cell(b, i * 7);
    run_solve(b, 1, 1'b0);
    // Nibbles above 9 pass through untouched
    run_solve({NC{4'hF}}, 1, 1'b0);
    // Start pulse while busy is ignored
    run_solve(b, 1, 1'b1);

    // Reset during the second pass's wait
    fill_n = 1;
    @(negedge clk);
    bus.board_in = b;
    bus.start_in = 1'b1;
    @(posedge clk);
    #1 bus.start_in = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("mid_busy", bus.busy_out, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", bus.busy_out, 1'b0);
    check("mid_rst_done", bus.done_out, 1'b0);
    check("mid_rst_status", bus.status_out, 2'b00);
    check("mid_rst_iter", bus.iter_out, 0);
    check("mid_rst_board", bus.board_out, '0);
    check("mid_rst_work", bus.solver_board_out, '0);
    @(negedge clk);
    rst_n = 1'b1;
    d1 = 0;
    for (int j = 0; j < 15; j++) begin
      @(posedge clk);
      #1;
      if (bus.done_out) d1++;
    end
    check("post_rst_no_done", d1, 0);
    run_solve(clear_cell(valid_board(), 40), 1, 1'b0);

    // Start held high: back-to-back solves
    fill_n = 1;
    @(negedge clk);
    bus.board_in = valid_board();
    bus.start_in = 1'b1;
    n = 0;
    d1 = 0;
    d2 = 0;
    while (n < 60 && d2 == 0) begin
      @(posedge clk);
      n++;
      #1;
      if (bus.done_out) begin
        if (d1 == 0) d1 = n;
        else         d2 = n;
      end
    end
    bus.start_in = 1'b0;
    check("b2b_first", d1, 3);
    check("b2b_second", d2, 7);
    check("b2b_status", bus.status_out, 2'b01);
    @(posedge clk);

    // Randomized boards and solver strengths
    for (int t = 0; t < 40; t++) begin
      b = rand_full();
      for (int z = $urandom_range(8, 0); z > 0; z--) b = clear_cell(b, $urandom_range(NC - 1, 0));
      run_solve(b, $urandom_range(3, 0), 1'($urandom_range(1, 0)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
